// File: rtl/risc_v_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_v_pkg
// Description : Shared control-field widths, branch/jump/pcSrc codes and the
//               next-PC select helper used by the decoder and control pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_v_pkg;

    localparam int c_RESULT_SRC_W  = 2;
    localparam int c_JUMP_W        = 2;
    localparam int c_BRANCH_W      = 3;
    localparam int c_ALU_CONTROL_W = 3;
    localparam int c_PC_SRC_W      = 2;

    typedef enum logic [c_BRANCH_W-1:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100
    } branch_t;

    typedef enum logic [c_JUMP_W-1:0] {
        JMP_NONE = 2'b00,
        JMP_JAL  = 2'b01,
        JMP_JALR = 2'b10
    } jump_t;

    typedef enum logic [c_PC_SRC_W-1:0] {
        PC_PLUS4  = 2'b00,
        PC_TARGET = 2'b01,
        PC_ALU    = 2'b10
    } pcSrc_t;

    typedef struct packed {
        logic                       regWrite;
        logic [c_RESULT_SRC_W-1:0]  resultSrc;
        logic                       memWrite;
        logic [c_JUMP_W-1:0]        jump;
        logic [c_BRANCH_W-1:0]      branch;
        logic [c_ALU_CONTROL_W-1:0] aluControl;
        logic                       aluSrc;
        logic                       lui;
    } ctrlE_t;

    typedef struct packed {
        logic                       regWrite;
        logic [c_RESULT_SRC_W-1:0]  resultSrc;
        logic                       memWrite;
    } ctrlM_t;

    typedef struct packed {
        logic                       regWrite;
        logic [c_RESULT_SRC_W-1:0]  resultSrc;
    } ctrlW_t;

    localparam int c_CTRL_E_W = $bits(ctrlE_t);
    localparam int c_CTRL_M_W = $bits(ctrlM_t);
    localparam int c_CTRL_W_W = $bits(ctrlW_t);

    // Unassigned branch codes (101-111) fall to the default: never taken.
    function automatic logic branchTaken(
        input logic [c_BRANCH_W-1:0] branch,
        input logic                  zero,
        input logic                  lt
    );
        logic taken;
        taken = 1'b0;
        case (branch)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_BLT:  taken = lt;
            BR_BGE:  taken = ~lt;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // jalr wins over any branch code carried by the same instruction.
    function automatic pcSrc_t pcSelect(
        input logic [c_JUMP_W-1:0]   jump,
        input logic [c_BRANCH_W-1:0] branch,
        input logic                  zero,
        input logic                  lt
    );
        pcSrc_t sel;
        sel = PC_PLUS4;
        if (jump == JMP_JALR) begin
            sel = PC_ALU;
        end else if ((jump == JMP_JAL) || branchTaken(branch, zero, lt)) begin
            sel = PC_TARGET;
        end
        return sel;
    endfunction

endpackage : risc_v_pkg
`default_nettype wire

// File: rtl/risc_v_control_pipe_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg
// Description : Generic pipeline stage register, async reset, sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : pipe_reg
`default_nettype wire

// File: rtl/risc_v_control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : risc_v_control_pipe
// Description : D->E->M->W control pipeline with E-stage next-PC select.
//               Define RISC_V_CTRL_PIPE_PERF_EN to add flush/taken counters.
// Revision    : 1.0 - initial release
// ============================================================================
module risc_v_control_pipe
    import risc_v_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flushE,
    input  logic        regWriteD,
    input  logic [1:0]  resultSrcD,
    input  logic        memWriteD,
    input  logic [1:0]  jumpD,
    input  logic [2:0]  branchD,
    input  logic [2:0]  ALUControlD,
    input  logic        ALUSrcD,
    input  logic        luiD,
    input  logic        zeroE,
    input  logic        ltE,
    output logic        regWriteE,
    output logic [1:0]  resultSrcE,
    output logic        memWriteE,
    output logic [2:0]  ALUControlE,
    output logic        ALUSrcE,
    output logic        luiE,
    output logic        resultSrcE0,
    output logic [1:0]  pcSrcE,
    output logic        regWriteM,
    output logic [1:0]  resultSrcM,
    output logic        memWriteM,
    output logic        regWriteW,
`ifdef RISC_V_CTRL_PIPE_PERF_EN
    output logic [15:0] flushCount,
    output logic [15:0] takenCount,
`endif
    output logic [1:0]  resultSrcW
);

    ctrlE_t                w_ctrlD;
    ctrlE_t                w_ctrlE;
    ctrlM_t                w_ctrlMIn;
    ctrlM_t                w_ctrlM;
    ctrlW_t                w_ctrlWIn;
    ctrlW_t                w_ctrlW;
    logic [c_CTRL_E_W-1:0] r_ctrlE;
    logic [c_CTRL_M_W-1:0] r_ctrlM;
    logic [c_CTRL_W_W-1:0] r_ctrlW;
    pcSrc_t                w_pcSrc;

    always_comb begin
        w_ctrlD            = '0;
        w_ctrlD.regWrite   = regWriteD;
        w_ctrlD.resultSrc  = resultSrcD;
        w_ctrlD.memWrite   = memWriteD;
        w_ctrlD.jump       = jumpD;
        w_ctrlD.branch     = branchD;
        w_ctrlD.aluControl = ALUControlD;
        w_ctrlD.aluSrc     = ALUSrcD;
        w_ctrlD.lui        = luiD;
    end

    // flushE zeroes the whole E word, so a bubble can never write reg/mem later.
    pipe_reg #(
        .WIDTH (c_CTRL_E_W)
    ) u_regE (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flushE),
        .i_d   (w_ctrlD),
        .o_q   (r_ctrlE)
    );

    assign w_ctrlE = ctrlE_t'(r_ctrlE);

    always_comb begin
        w_ctrlMIn           = '0;
        w_ctrlMIn.regWrite  = w_ctrlE.regWrite;
        w_ctrlMIn.resultSrc = w_ctrlE.resultSrc;
        w_ctrlMIn.memWrite  = w_ctrlE.memWrite;
    end

    pipe_reg #(
        .WIDTH (c_CTRL_M_W)
    ) u_regM (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_d   (w_ctrlMIn),
        .o_q   (r_ctrlM)
    );

    assign w_ctrlM = ctrlM_t'(r_ctrlM);

    always_comb begin
        w_ctrlWIn           = '0;
        w_ctrlWIn.regWrite  = w_ctrlM.regWrite;
        w_ctrlWIn.resultSrc = w_ctrlM.resultSrc;
    end

    pipe_reg #(
        .WIDTH (c_CTRL_W_W)
    ) u_regW (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_d   (w_ctrlWIn),
        .o_q   (r_ctrlW)
    );

    assign w_ctrlW = ctrlW_t'(r_ctrlW);

    // Next-PC select is driven from the instruction currently in E, flush or not.
    assign w_pcSrc = pcSelect(w_ctrlE.jump, w_ctrlE.branch, zeroE, ltE);

    assign regWriteE   = w_ctrlE.regWrite;
    assign resultSrcE  = w_ctrlE.resultSrc;
    assign memWriteE   = w_ctrlE.memWrite;
    assign ALUControlE = w_ctrlE.aluControl;
    assign ALUSrcE     = w_ctrlE.aluSrc;
    assign luiE        = w_ctrlE.lui;
    assign resultSrcE0 = w_ctrlE.resultSrc[0];
    assign pcSrcE      = w_pcSrc;

    assign regWriteM   = w_ctrlM.regWrite;
    assign resultSrcM  = w_ctrlM.resultSrc;
    assign memWriteM   = w_ctrlM.memWrite;

    assign regWriteW   = w_ctrlW.regWrite;
    assign resultSrcW  = w_ctrlW.resultSrc;

`ifdef RISC_V_CTRL_PIPE_PERF_EN
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [15:0] r_flushCount;
    logic [15:0] r_takenCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flushCount <= '0;
            r_takenCount <= '0;
        end else begin
            if (flushE && (r_flushCount != c_CNT_MAX)) begin
                r_flushCount <= r_flushCount + 16'd1;
            end
            if ((w_pcSrc != PC_PLUS4) && (r_takenCount != c_CNT_MAX)) begin
                r_takenCount <= r_takenCount + 16'd1;
            end
        end
    end

    assign flushCount = r_flushCount;
    assign takenCount = r_takenCount;
`endif

endmodule : risc_v_control_pipe
`default_nettype wire

// File: doc/risc_v_control_pipe.md
RISC_V_CONTROL_PIPE -- requirements
Module: risc_v_control_pipe

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all registers rise-edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port flushE, input, 1, synchronous clear of the D->E register (bubble insert).
REQ-004 SHALL have D-stage inputs: regWriteD 1, resultSrcD 2, memWriteD 1, jumpD 2, branchD 3, ALUControlD 3, ALUSrcD 1, luiD 1, all decoder outputs.
REQ-005 SHALL have inputs zeroE 1 and ltE 1: ALU flags of the E-stage instruction, combinational, same cycle.
REQ-006 SHALL have E outputs: regWriteE, resultSrcE 2, memWriteE, ALUControlE 3, ALUSrcE, luiE, resultSrcE0 1 (load-in-E flag for hazard unit).
REQ-007 SHALL have output pcSrcE, 2: 00 PC+4, 01 PC-relative target, 10 ALU result (jalr).
REQ-008 SHALL have M outputs regWriteM, resultSrcM 2, memWriteM; W outputs regWriteW, resultSrcW 2.

Function
REQ-009 SHALL register all D control inputs into the E stage on every clk edge when flushE=0.
REQ-010 SHALL load all-zero E controls (bubble) on a clk edge with flushE=1, regardless of D inputs.
REQ-011 SHALL advance E->M and M->W unconditionally each edge; M and W stages never stall or flush.
REQ-012 SHALL give one cycle latency per stage: a D value appears on E outputs 1 edge later, M 2 edges, W 3 edges.
REQ-013 SHALL decode branchE: 000 none, 001 beq (taken if zeroE), 010 bne (taken if !zeroE), 011 blt (taken if ltE), 100 bge (taken if !ltE); codes 101-111 never taken.
REQ-014 SHALL decode jumpE: 00 none, 01 jal, 10 jalr, 11 treated as none.
REQ-015 SHALL drive pcSrcE combinationally: 10 if jumpE=10; else 01 if jumpE=01 or branch taken; else 00.
REQ-016 SHALL give jalr priority over any simultaneous branch code in the same E instruction.
REQ-017 SHALL drive resultSrcE0 = resultSrcE[0].
REQ-018 SHALL, when flushE=1 and a taken branch are in the same cycle, drive pcSrcE from the current E instruction and bubble the next E contents.
REQ-019 SHALL never let a flushed (bubble) instruction assert regWriteM/W or memWriteM.

Reset
REQ-020 SHALL clear every E, M, W register to 0 immediately on rst=1, independent of clk.
REQ-021 SHALL hold all outputs at 0 (pcSrcE=00) while rst=1; first D capture on first edge after rst falls.
REQ-022 SHALL discard all in-flight instructions when rst asserts mid-operation; no partial state survives.

Configuration
REQ-023 SHALL, with RISC_V_CTRL_PIPE_PERF_EN defined, add outputs flushCount 16 and takenCount 16: saturating counters of edges with flushE=1 and of cycles with pcSrcE!=00, cleared by rst.
REQ-024 SHALL, without RISC_V_CTRL_PIPE_PERF_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-025 SHALL place branch codes, jump codes, pcSrc encodings and control field widths in shared package risc_v_pkg, also used by the decoder.
REQ-026 SHALL build each stage register from one sub-module pipe_reg (parameter WIDTH, async rst, sync clr).

Verification
REQ-027 SHALL test: rst=1 mid-stream with regWriteD=1 in D/E/M -> all outputs 0 same cycle, regWriteW=0 until 3 edges after release.
REQ-028 SHALL test: regWriteD=1, resultSrcD=01 at edge 0 -> resultSrcE0=1 after edge 1, regWriteM=1 after edge 2, regWriteW=1, resultSrcW=01 after edge 3.
REQ-029 SHALL test: branchD=001 then zeroE=1 -> pcSrcE=01; zeroE=0 -> 00; branchD=100, ltE=0 -> 01; branchD=111 -> 00.
REQ-030 SHALL test: jumpD=10 with branchD=001, zeroE=1 -> pcSrcE=10.
REQ-031 SHALL test: memWriteD=1 with flushE=1 at capture edge -> memWriteE, memWriteM stay 0 for subsequent edges.
REQ-032 SHALL test with RISC_V_CTRL_PIPE_PERF_EN: 70000 edges flushE=1 -> flushCount=65535, no wrap.
